// File: rtl/line_buffer_pkg.sv
// Shared types and constants for the line-buffer frame scheduler.
package line_buffer_pkg;

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned RD_LAT = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SOF    = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_e;

    function automatic int unsigned frame_len(input int unsigned x, input int unsigned y);
        return x * y;
    endfunction

endpackage

// File: rtl/line_buffer_frame_scheduler_if.sv
// Feature-memory / line-buffer side of the scheduler; master = scheduler.
interface line_buffer_frame_scheduler_if #(
    parameter int unsigned ADDR_W = 16
) ();

    logic              pe_ready;
    logic              lb_output_valid;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              lb_sof;
    logic              lb_input_valid;

    modport master (
        input  pe_ready, lb_output_valid,
        output mem_rd_en, mem_addr, lb_sof, lb_input_valid
    );

    modport slave (
        output pe_ready, lb_output_valid,
        input  mem_rd_en, mem_addr, lb_sof, lb_input_valid
    );

endinterface

// File: rtl/frame_addr_gen.sv
// Read counter, channel index and registered feature-memory address.
module frame_addr_gen
    import line_buffer_pkg::*;
#(
    parameter int unsigned INPUT_Y   = 3,
    parameter int unsigned INPUT_X   = 3,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              clear,
    input  logic              next_ch,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CNT_W-1:0]  ch_idx,
    output logic              last_rd
);

    localparam int unsigned N = frame_len(INPUT_X, INPUT_Y);

    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  ch_idx_q, ch_idx_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    // clear starts a new layer; next_ch rewinds the pixel count for the next channel
    always_comb begin
        rd_cnt_d   = rd_cnt_q;
        ch_idx_d   = ch_idx_q;
        mem_addr_d = mem_addr_q;
        if (clear) begin
            rd_cnt_d = '0;
            ch_idx_d = '0;
        end else if (next_ch) begin
            rd_cnt_d = '0;
            ch_idx_d = ch_idx_q + CNT_W'(1);
        end else if (advance) begin
            rd_cnt_d   = rd_cnt_q + CNT_W'(1);
            mem_addr_d = ADDR_W'(BASE_ADDR + 32'(ch_idx_q) * N + 32'(rd_cnt_q));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt_q   <= '0;
            ch_idx_q   <= '0;
            mem_addr_q <= '0;
        end else begin
            rd_cnt_q   <= rd_cnt_d;
            ch_idx_q   <= ch_idx_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign ch_idx   = ch_idx_q;
    assign last_rd  = (rd_cnt_q == CNT_W'(N - 1));

endmodule

// File: rtl/line_buffer_frame_scheduler.sv
// Streams each channel of a feature map through the 3x3 line buffer, then waits for it to drain.
// Optional SCHED_WATCHDOG_EN adds a DRAIN timeout with sticky err_timeout.
module line_buffer_frame_scheduler
    import line_buffer_pkg::*;
#(
    parameter int unsigned INPUT_Y   = 3,
    parameter int unsigned INPUT_X   = 3,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    line_buffer_frame_scheduler_if.master lb_if,
    output logic [CNT_W-1:0]              ch_idx,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          done
`ifdef SCHED_WATCHDOG_EN
    ,
    output logic                          err_timeout
`endif
);

    localparam int unsigned      N       = frame_len(INPUT_X, INPUT_Y);
    localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N);
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(NUM_CH - 1);

    state_e             state_q, state_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               done_q, done_d;
    logic               lb_sof_q, lb_sof_d;
    logic               mem_rd_en_q, mem_rd_en_d;
    logic [RD_LAT-1:0]  rd_pipe_q, rd_pipe_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               advance, clear, next_ch, last_rd, in_flight;
    logic [ADDR_W-1:0]  mem_addr;

`ifdef SCHED_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(4 * N);
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             err_q, err_d;
`endif

    frame_addr_gen #(
        .INPUT_Y  (INPUT_Y),
        .INPUT_X  (INPUT_X),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(BASE_ADDR)
    ) u_addr_gen (
        .clk     (clk),
        .rst     (rst),
        .advance (advance),
        .clear   (clear),
        .next_ch (next_ch),
        .mem_addr(mem_addr),
        .ch_idx  (ch_idx),
        .last_rd (last_rd)
    );

    // a read is in flight until its pixel has left the memory pipe
    assign in_flight = mem_rd_en_q | (|rd_pipe_q);

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        done_d       = 1'b0;
        lb_sof_d     = 1'b0;
        mem_rd_en_d  = 1'b0;
        out_cnt_d    = out_cnt_q;
        advance      = 1'b0;
        clear        = 1'b0;
        next_ch      = 1'b0;
        rd_pipe_d    = RD_LAT'({rd_pipe_q, mem_rd_en_q});
`ifdef SCHED_WATCHDOG_EN
        err_d  = err_q;
        wdog_d = '0;
        if (state_q == DRAIN)
            wdog_d = lb_if.lb_output_valid ? '0 : wdog_q + CNT_W'(1);
`endif
        if ((state_q == STREAM || state_q == DRAIN) && lb_if.lb_output_valid && out_cnt_q != N_CNT)
            out_cnt_d = out_cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SOF;
                    busy_d   = 1'b1;
                    lb_sof_d = 1'b1;
                    clear    = 1'b1;
`ifdef SCHED_WATCHDOG_EN
                    err_d    = 1'b0;
`endif
                end
            end
            SOF: begin
                out_cnt_d = '0;
                state_d   = STREAM;
            end
            STREAM: begin
                if (lb_if.pe_ready) begin
                    advance     = 1'b1;
                    mem_rd_en_d = 1'b1;
                    if (last_rd) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // waiting for in_flight keeps the next sof clear of the last pixel
                if (out_cnt_q == N_CNT && !in_flight) begin
                    frame_done_d = 1'b1;
                    if (ch_idx == LAST_CH) begin
                        state_d = DONE;
                    end else begin
                        next_ch  = 1'b1;
                        lb_sof_d = 1'b1;
                        state_d  = SOF;
                    end
                end
`ifdef SCHED_WATCHDOG_EN
                else if (wdog_d == WDOG_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            done_q       <= 1'b0;
            lb_sof_q     <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            rd_pipe_q    <= '0;
            out_cnt_q    <= '0;
`ifdef SCHED_WATCHDOG_EN
            wdog_q       <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            done_q       <= done_d;
            lb_sof_q     <= lb_sof_d;
            mem_rd_en_q  <= mem_rd_en_d;
            rd_pipe_q    <= rd_pipe_d;
            out_cnt_q    <= out_cnt_d;
`ifdef SCHED_WATCHDOG_EN
            wdog_q       <= wdog_d;
            err_q        <= err_d;
`endif
        end
    end

    assign lb_if.mem_rd_en      = mem_rd_en_q;
    assign lb_if.mem_addr       = mem_addr;
    assign lb_if.lb_sof         = lb_sof_q;
    assign lb_if.lb_input_valid = rd_pipe_q[RD_LAT-1];
    assign busy                 = busy_q;
    assign frame_done           = frame_done_q;
    assign done                 = done_q;
`ifdef SCHED_WATCHDOG_EN
    assign err_timeout          = err_q;
`endif

endmodule

// File: tb/tb_line_buffer_frame_scheduler.sv
// Directed bench for line_buffer_frame_scheduler (3x3, two channels) with a delayed-echo line-buffer model.
module tb_line_buffer_frame_scheduler;
    import line_buffer_pkg::*;

    localparam int unsigned AW = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] ch_idx;
    logic             busy, frame_done, done;
`ifdef SCHED_WATCHDOG_EN
    logic             err_timeout;
`endif

    line_buffer_frame_scheduler_if #(.ADDR_W(AW)) bus ();

    line_buffer_frame_scheduler #(
        .INPUT_Y(3), .INPUT_X(3), .NUM_CH(2), .ADDR_W(AW), .BASE_ADDR(0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .lb_if      (bus),
        .ch_idx     (ch_idx),
        .busy       (busy),
        .frame_done (frame_done),
        .done       (done)
`ifdef SCHED_WATCHDOG_EN
        ,
        .err_timeout(err_timeout)
`endif
    );

    always #5 clk = ~clk;

    // line-buffer stand-in: every accepted pixel returns as one output_valid four cycles later
    logic [3:0] echo_q;
    int         emitted = 0;
    int         echo_limit = 1000000;
    logic       ov_force = 1'b0;
    logic       ov_gate;
    assign ov_gate = echo_q[3] && (emitted < echo_limit);
    assign bus.lb_output_valid = ov_gate | ov_force;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            echo_q  <= '0;
            emitted <= 0;
        end else begin
            echo_q <= {echo_q[2:0], bus.lb_input_valid};
            if (ov_gate) emitted <= emitted + 1;
        end
    end

    int rd_log[$];
    int sof_cnt = 0, sof_clash = 0, iv_cnt = 0;
    always @(posedge clk) begin
        if (rst) begin
            if (bus.mem_rd_en) rd_log.push_back(int'(bus.mem_addr));
            if (bus.lb_sof) sof_cnt++;
            if (bus.lb_sof && bus.lb_input_valid) sof_clash++;
            if (bus.lb_input_valid) iv_cnt++;
        end
    end

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input string tag, input int base);
        chk({tag, "_len"}, 32'(rd_log.size() - base), 18);
        for (int i = 0; i < 18; i++)
            if (base + i < rd_log.size()) chk(tag, 32'(rd_log[base + i]), i);
    endtask

    task automatic wait_fd(input int budget, output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (frame_done !== 1'b1 && cyc < budget);
    endtask

    task automatic wait_done(input int budget);
        int cyc = 0;
        do begin @(negedge clk); cyc++; end while (done !== 1'b1 && cyc < budget);
        chk("done_seen", 32'(done), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(bus.mem_rd_en), 0);
        chk({tag, "_addr"},  32'(bus.mem_addr), 0);
        chk({tag, "_sof"},   32'(bus.lb_sof), 0);
        chk({tag, "_iv"},    32'(bus.lb_input_valid), 0);
        chk({tag, "_ch"},    32'(ch_idx), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_fd"},    32'(frame_done), 0);
        chk({tag, "_done"},  32'(done), 0);
    endtask

    initial begin
        int base, sof_base, iv_base, cyc;
        bus.pe_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        bus.pe_ready = 1'b1;
        @(negedge clk);

        // output_valid while idle must not wake the scheduler
        ov_force = 1'b1;
        repeat (3) @(negedge clk);
        ov_force = 1'b0;
        chk("idle_ov_busy", 32'(busy), 0);
        chk("idle_ov_fd", 32'(frame_done), 0);
        chk("idle_ov_done", 32'(done), 0);

        // two full channels, pe_ready held high
        base = rd_log.size(); sof_base = sof_cnt; iv_base = iv_cnt;
        pulse_start();
        chk("t1_sof", 32'(bus.lb_sof), 1);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_sof_iv", 32'(bus.lb_input_valid), 0);
        chk("t1_sof_rd", 32'(bus.mem_rd_en), 0);
        chk("t1_ch0", 32'(ch_idx), 0);
        @(negedge clk);
        chk("t1_sof_once", 32'(bus.lb_sof), 0);
        chk("t1_no_rd_yet", 32'(bus.mem_rd_en), 0);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t1_rd_en", 32'(bus.mem_rd_en), 1);
            chk("t1_addr", 32'(bus.mem_addr), i);
        end
        wait_fd(40, cyc);
        chk("t1_fd0_latency", cyc, 7);
        chk("t1_fd0_sof", 32'(bus.lb_sof), 1);
        chk("t1_fd0_ch1", 32'(ch_idx), 1);
        chk("t1_fd0_iv", 32'(bus.lb_input_valid), 0);
        chk("t1_fd0_busy", 32'(busy), 1);
        chk("t1_fd0_done", 32'(done), 0);
        wait_fd(40, cyc);
        chk("t1_fd1_latency", cyc, 17);
        chk("t1_fd1_ch1", 32'(ch_idx), 1);
        @(negedge clk);
        chk("t1_done", 32'(done), 1);
        chk("t1_done_busy", 32'(busy), 0);
        chk("t1_done_fd", 32'(frame_done), 0);
        @(negedge clk);
        chk("t1_done_pulse", 32'(done), 0);
        chk("t1_idle_busy", 32'(busy), 0);
        chk_log("t1_log", base);
        chk("t1_sof_count", 32'(sof_cnt - sof_base), 2);
        chk("t1_iv_count", 32'(iv_cnt - iv_base), 18);

        // pe_ready low for three cycles right after address 4
        base = rd_log.size(); iv_base = iv_cnt;
        pulse_start();
        chk("t2_sof", 32'(bus.lb_sof), 1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_addr_pre", 32'(bus.mem_addr), i);
        end
        bus.pe_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_stall_rd", 32'(bus.mem_rd_en), 0);
            chk("t2_stall_addr", 32'(bus.mem_addr), 4);
        end
        bus.pe_ready = 1'b1;
        for (int i = 5; i < 9; i++) begin
            @(negedge clk);
            chk("t2_rd_en", 32'(bus.mem_rd_en), 1);
            chk("t2_addr_post", 32'(bus.mem_addr), i);
        end
        wait_done(100);
        chk_log("t2_log", base);
        chk("t2_iv_count", 32'(iv_cnt - iv_base), 18);

        // start during STREAM is ignored, then reset lands at read 5
        pulse_start();
        chk("t3_sof", 32'(bus.lb_sof), 1);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            start = (i == 3) ? 1'b1 : 1'b0;
            @(negedge clk);
            chk("t3_addr", 32'(bus.mem_addr), i);
            chk("t3_no_sof", 32'(bus.lb_sof), 0);
        end
        start = 1'b0;
        #2 rst = 1'b0;
        #1 chk_all_zero("t3_async_rst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t3_idle_busy", 32'(busy), 0);
        base = rd_log.size(); sof_base = sof_cnt;
        pulse_start();
        chk("t3_restart_sof", 32'(bus.lb_sof), 1);
        chk("t3_restart_ch", 32'(ch_idx), 0);
        chk("t3_restart_busy", 32'(busy), 1);
        @(negedge clk);
        @(negedge clk);
        chk("t3_restart_addr", 32'(bus.mem_addr), 0);
        wait_done(100);
        chk_log("t3_log", base);
        chk("t3_sof_count", 32'(sof_cnt - sof_base), 2);
        chk("sof_iv_clash", 32'(sof_clash), 0);

`ifdef SCHED_WATCHDOG_EN
        // line buffer stalls after five outputs: timeout, done, then cleared by next start
        echo_limit = emitted + 5;
        pulse_start();
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (err_timeout !== 1'b1 && cyc < 120);
        chk("wd_err", 32'(err_timeout), 1);
        chk("wd_no_fd", 32'(frame_done), 0);
        @(negedge clk);
        chk("wd_done", 32'(done), 1);
        @(negedge clk);
        chk("wd_idle_busy", 32'(busy), 0);
        chk("wd_sticky", 32'(err_timeout), 1);
        echo_limit = 1000000;
        pulse_start();
        chk("wd_err_clear", 32'(err_timeout), 0);
        wait_done(100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_buffer_frame_scheduler.md
Name: line_buffer_frame_scheduler

Overview:
Sequences the stride-1 / padding-same 3x3 line buffer across a multi-channel feature map. On start, for each channel it pulses sof, fetches INPUT_X*INPUT_Y pixels from feature memory in column-major order (y inner, x outer) and drives the line buffer's input_valid. It then counts the line buffer's output_valid pulses until the whole frame has drained, and advances to the next channel. Sits between the layer controller (start/done) and the feature SRAM / line buffer pair.

Parameters:
INPUT_Y, 3, rows per channel (inner scan dimension)
INPUT_X, 3, columns per channel (outer scan dimension)
NUM_CH, 2, channels per layer
ADDR_W, 16, feature-memory address width
BASE_ADDR, 0, address of pixel 0 of channel 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
start  in  1  one-cycle pulse, begins a layer; ignored unless IDLE
pe_ready  in  1  downstream ready; 0 stalls new memory reads
lb_output_valid  in  1  output_valid from line buffer
mem_rd_en  out  1  feature-memory read strobe
mem_addr  out  ADDR_W  feature-memory read address
lb_sof  out  1  start-of-frame pulse to line buffer
lb_input_valid  out  1  pixel valid to line buffer; read data valid same cycle
ch_idx  out  16  channel currently streamed
busy  out  1  high from accepted start until done
frame_done  out  1  one-cycle pulse when a channel's outputs have all been seen
done  out  1  one-cycle pulse after last channel

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0; mem_addr=0; all counters 0.
- Define N = INPUT_X*INPUT_Y. Counters are 16 bit. Address arithmetic is modulo 2^ADDR_W.
- mem_addr = BASE_ADDR + ch_idx*N + rd_cnt, registered.
- Memory latency is fixed at 1 cycle, so lb_input_valid = mem_rd_en delayed one clock.
- States:
  - IDLE: on start -> SOF; busy<=1; ch_idx<=0.
  - SOF: lb_sof=1 for exactly one cycle with lb_input_valid=0; clear rd_cnt, out_cnt -> STREAM.
  - STREAM: each cycle with pe_ready=1 and rd_cnt<N: mem_rd_en=1, rd_cnt++. On issuing read N-1 -> DRAIN.
    - pe_ready=0: mem_rd_en=0; addr held; no skipped or duplicated address.
  - DRAIN: no reads. Counts lb_output_valid (also counted in STREAM) until out_cnt==N.
    - Drain outputs are not gated by pe_ready: the line buffer self-drains and the consumer must accept them.
  - DRAIN exit (out_cnt reaches N): frame_done pulse. If ch_idx==NUM_CH-1 -> DONE, else ch_idx++ -> SOF.
  - DONE: done=1, busy<=0 for one cycle -> IDLE.
- Boundary rules:
  - start while busy: ignored.
  - lb_output_valid in IDLE: ignored.
  - out_cnt saturates at N.
  - Second sof is never issued in the same cycle as lb_input_valid: at least one idle cycle separates the last pixel of channel c from sof of channel c+1.
  - Reset mid-frame: immediate return to IDLE. The next start re-issues sof, which re-arms the line buffer.

Optional Feature:
SCHED_WATCHDOG_EN
- Defined: a 16-bit counter runs in DRAIN and clears on each lb_output_valid. Reaching WDOG_LIMIT (localparam 4*N) asserts sticky output err_timeout, pulses done and returns to IDLE. err_timeout clears on the next start.
- Undefined: port err_timeout absent; DRAIN waits indefinitely.

Decomposition:
- Shared package line_buffer_pkg holds:
  - state encodings (IDLE, SOF, STREAM, DRAIN, DONE, 3 bit)
  - counter width constant CNT_W=16
  - the memory latency constant RD_LAT=1
- One sub-module, frame_addr_gen: holds rd_cnt and ch_idx and produces mem_addr and the last-read flag. Its inputs are advance, clear and next_ch.

Test Plan:
- 3x3, NUM_CH=1, pe_ready=1, line buffer attached; start -> lb_sof at cycle 1, addresses 0..8 on consecutive cycles, 9 output_valid counted, frame_done then done, busy low after done.
- NUM_CH=2 -> channel 1 addresses 9..17; exactly one sof per channel, never coincident with lb_input_valid; ch_idx 0 then 1.
- pe_ready low for 3 cycles after address 4 -> address 4 issued once, next read is address 5, 9 reads total.
- start pulsed again mid-STREAM -> ignored, address sequence unchanged; rst=0 at read 5 -> all outputs 0 asynchronously; new start restarts at address 0 with sof.
- Watchdog build: withhold lb_output_valid after 5 outputs -> err_timeout after 36 DRAIN cycles, done pulse, IDLE; next start clears err_timeout.
